// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan-FSM state encoding and segment constants for the 7-segment scan controller
package seg7_pkg;
    typedef enum logic {ST_GUARD = 1'b0, ST_SHOW = 1'b1} state_t;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
endpackage

// File: rtl/seg7_bcd_dec.sv
// seg7_bcd_dec: combinational BCD to active-high {a,b,c,d,e,f,g} decode, dash for codes 10-15
//   bcd  in  4  BCD nibble
//   seg  out 7  segment pattern, seg[6]=a .. seg[0]=g
module seg7_bcd_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed NDIG-digit 7-segment scan controller with guard blanking and frame-aligned word load
//   clk, rst    clock, synchronous active-high reset
//   load_valid  in   new display word offered
//   load_ready  out  word can be accepted (no word pending)
//   load_data   in   4*NDIG BCD nibbles, [3:0] = digit 0
//   blank_lz    in   suppress leading zeros
//   seg         out  registered segment pattern
//   dig_en      out  registered one-hot digit enable
//   frame_done  out  pulse on the last cycle of the final digit slot
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int PRESCALE    = 1000,
    parameter int BLANK_GUARD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4*NDIG-1:0] load_data,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_done
);
    localparam int MX = PRESCALE > BLANK_GUARD ? PRESCALE : BLANK_GUARD;
    localparam int CW = $clog2(MX + 1);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    state_t            state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [IW-1:0]     idx, idx_n;
    logic [4*NDIG-1:0] active, active_n, pending;
    logic              pend_v, xfer, last, z, lz_hit;
    logic [NDIG-1:0]   lz;
    logic [3:0]        nib;
    logic [6:0]        dec;

    assign load_ready = ~pend_v;
    assign xfer       = load_valid && load_ready;
    // A zero-length guard still occupies the single post-reset cycle, then is never re-entered.
    assign last = state == ST_GUARD ? (BLANK_GUARD <= 1 || count == CW'(BLANK_GUARD > 0 ? BLANK_GUARD - 1 : 0))
                                    : count == CW'(PRESCALE - 1);

    // Outputs are registered from the next-cycle state so they describe the cycle they are visible in.
    always_comb begin
        state_n  = state == ST_GUARD ? (last ? ST_SHOW : ST_GUARD)
                                     : (last && BLANK_GUARD > 0 ? ST_GUARD : ST_SHOW);
        count_n  = last ? '0 : count + 1'b1;
        idx_n    = state == ST_SHOW && last ? (idx == IW'(NDIG - 1) ? '0 : idx + 1'b1) : idx;
        active_n = frame_done ? (pend_v ? pending : xfer ? load_data : active) : active;
    end

    // lz[i]: nibbles i..NDIG-1 of the word being shown are all zero (digit 0 exempt).
    always_comb begin
        z  = 1'b1;
        lz = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            z     = z && active_n[4*i +: 4] == 4'd0;
            lz[i] = z && i != 0;
        end
    end

    assign nib    = active_n[4*idx_n +: 4];
    assign lz_hit = blank_lz && lz[idx_n];

    seg7_bcd_dec u_dec (.bcd(nib), .seg(dec));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GUARD;
            count      <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            seg        <= SEG_OFF;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            idx        <= idx_n;
            active     <= active_n;
            pending    <= xfer && !frame_done ? load_data : pending;
            pend_v     <= frame_done ? 1'b0 : (xfer ? 1'b1 : pend_v);
            seg        <= state_n == ST_SHOW && !lz_hit ? dec : SEG_OFF;
            dig_en     <= state_n == ST_SHOW && !lz_hit ? NDIG'(1) << idx_n : '0;
            frame_done <= state_n == ST_SHOW && idx_n == IW'(NDIG - 1) && count_n == CW'(PRESCALE - 1);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl (NDIG=4, PRESCALE=4, BLANK_GUARD=1)
module tb_seg7_scan_ctrl;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001,
                           S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S9 = 7'b1111011,
                           SD = 7'b0000001, SO = 7'b0000000;

    logic        clk = 1'b0, rst = 1'b1, load_valid = 1'b0, blank_lz = 1'b0;
    logic        load_ready, frame_done;
    logic [15:0] load_data = '0;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    int          n_cmp = 0, n_err = 0, n;

    seg7_scan_ctrl #(.NDIG(4), .PRESCALE(4), .BLANK_GUARD(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_lz(blank_lz), .seg(seg), .dig_en(dig_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_fd(output int c);
        c = 0;
        do begin
            step(1);
            c++;
        end while (!frame_done && c < 64);
        if (!frame_done) chk("fd_timeout", 32'(c), 32'd0);
    endtask

    // Called on the frame_done cycle; checks the first SHOW cycle of each digit of the next frame.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [15:0] ens);
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 2 : 5);
            chk($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(segs[7*d +: 7]));
            chk($sformatf("%s_en%0d", tag, d), 32'(dig_en), 32'(ens[4*d +: 4]));
        end
    endtask

    task automatic load(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        step(1);
        load_valid = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        chk("rst_seg", 32'(seg), 32'(SO));
        chk("rst_en", 32'(dig_en), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_rdy", 32'(load_ready), 32'd1);
        step(1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_seg", 32'(seg), 32'(S0));
            chk("t1_en", 32'(dig_en), 32'b0001);
            step(1);
        end
        chk("t1_guard_en", 32'(dig_en), 32'd0);
        wait_fd(n);
        chk("t1_fd_first", 32'(n), 32'd14);
        wait_fd(n);
        chk("t1_fd_period", 32'(n), 32'd20);
        check_frame("t1", {S0, S0, S0, S0}, 16'b1000_0100_0010_0001);

        load(16'h1234);
        chk("t2_rdy", 32'(load_ready), 32'd0);
        wait_fd(n);
        check_frame("t2", {S1, S2, S3, S4}, 16'b1000_0100_0010_0001);

        load_valid = 1'b1;
        load_data  = 16'h1111;
        step(1);
        load_data  = 16'h2222;
        chk("t3_stall", 32'(load_ready), 32'd0);
        wait_fd(n);
        chk("t3_stall_fd", 32'(load_ready), 32'd0);
        step(1);
        chk("t3_rdy_back", 32'(load_ready), 32'd1);
        step(1);
        load_valid = 1'b0;
        chk("t3_taken", 32'(load_ready), 32'd0);
        chk("t3_1111_seg", 32'(seg), 32'(S1));
        wait_fd(n);
        check_frame("t3", {S2, S2, S2, S2}, 16'b1000_0100_0010_0001);

        blank_lz = 1'b1;
        load(16'h0050);
        wait_fd(n);
        check_frame("t4", {SO, SO, S5, S0}, 16'b0000_0000_0010_0001);

        blank_lz = 1'b0;
        load(16'h00AF);
        wait_fd(n);
        check_frame("t5", {S0, S0, SD, SD}, 16'b1000_0100_0010_0001);

        wait_fd(n);
        chk("byp_rdy_pre", 32'(load_ready), 32'd1);
        load(16'h9876);
        chk("byp_rdy_post", 32'(load_ready), 32'd1);
        step(1);
        chk("byp_seg0", 32'(seg), 32'(S6));
        chk("byp_en0", 32'(dig_en), 32'b0001);
        step(15);
        chk("byp_seg3", 32'(seg), 32'(S9));
        chk("byp_en3", 32'(dig_en), 32'b1000);

        wait_fd(n);
        step(1);
        load(16'h5555);
        chk("t6_pend", 32'(load_ready), 32'd0);
        step(11);
        chk("t6_pre_en", 32'(dig_en), 32'b0100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_seg", 32'(seg), 32'(SO));
        chk("t6_en", 32'(dig_en), 32'd0);
        chk("t6_fd", 32'(frame_done), 32'd0);
        chk("t6_rdy", 32'(load_ready), 32'd1);
        step(1);
        chk("t6_d0_seg", 32'(seg), 32'(S0));
        chk("t6_d0_en", 32'(dig_en), 32'b0001);
        wait_fd(n);
        chk("t6_fd_gap", 32'(n), 32'd18);
        check_frame("t6", {S0, S0, S0, S0}, 16'b1000_0100_0010_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
